button_event: RTL and testbench

Converts the debounced, synchronised button level from the debouncer into single-cycle event pulses for the VGA control logic (pattern select, cursor step). Outputs are press, release, long-press and auto-repeat strobes. The block sits directly downstream of the debouncer, one instance per button, in the `clk` domain. All outputs are registered.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_event.sv | 114 +++++++++++
 tb/tb_button_event.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing for every button_event instance.
package button_pkg;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HOLD = 2'd2,
        RPT  = 2'd3
    } btn_state_t;

    // 0.5 s long-press and 0.1 s repeat at 50 MHz
    localparam int BTN_LONG_CYCLES   = 25_000_000;
    localparam int BTN_REPEAT_CYCLES = 5_000_000;

    function automatic int btn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into registered press/release/long-press/repeat
// strobes plus a held flag; a button held through reset must be seen low first.
module button_event
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
    parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES,
    parameter int CNT_W         = $clog2(btn_max(LONG_CYCLES, REPEAT_CYCLES))
) (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        // A falling level is tested before any threshold so release always wins.
        unique case (state_q)
            ARM: begin
                cnt_d = '0;
                if (!level_i) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (level_i) begin
                    state_d = HOLD;
                    press_d = 1'b1;
                end
            end
            HOLD: begin
                if (!level_i) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = RPT;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RPT: begin
                if (!level_i) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARM;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == HOLD) || (state_d == RPT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARM;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign repeat_o     = repeat_q;
    assign held_o       = held_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed scenarios plus random hold lengths, all
// checked cycle by cycle against a hold-duration reference model.
module tb_button_event;

    localparam int L = 8;
    localparam int R = 3;

    logic clk;
    logic rst;
    logic level;
    logic press, release_s, long_press, repeat_s, held;

    int checks   = 0;
    int failures = 0;

    // reference model state: waiting-for-low flag, pressed flag, edges since press
    bit need_low;
    bit pressed;
    int hold_n;
    bit e_press, e_rel, e_long, e_rep;

    button_event #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .level_i     (level),
        .press_o     (press),
        .release_o   (release_s),
        .long_press_o(long_press),
        .repeat_o    (repeat_s),
        .held_o      (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge that sampled (r, l).
    task automatic model_edge(input bit r, input bit l);
        e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
        if (r) begin
            need_low = 1;
            pressed  = 0;
        end else if (need_low) begin
            if (!l) need_low = 0;
        end else if (!pressed) begin
            if (l) begin
                pressed = 1;
                hold_n  = 0;
                e_press = 1;
            end
        end else if (!l) begin
            pressed = 0;
            e_rel   = 1;
        end else begin
            hold_n++;
            if (hold_n == L)
                e_long = 1;
            else if (hold_n > L && ((hold_n - L) % R) == 0)
                e_rep = 1;
        end
    endtask

    task automatic step(input bit r, input bit l);
        rst   = r;
        level = l;
        @(posedge clk);
        model_edge(r, l);
        #1;
        chk("press",      press,      e_press);
        chk("release",    release_s,  e_rel);
        chk("long_press", long_press, e_long);
        chk("repeat",     repeat_s,   e_rep);
        chk("held",       held,       pressed);
        chk("onehot", ((press + release_s + long_press + repeat_s) <= 1) ? 1 : 0, 1);
    endtask

    task automatic run(input bit l, input int n);
        for (int i = 0; i < n; i++) step(1'b0, l);
    endtask

    task automatic do_reset(input bit l, input int n);
        for (int i = 0; i < n; i++) step(1'b1, l);
    endtask

    int long_seen;

    initial begin
        need_low = 1; pressed = 0; hold_n = 0;
        rst = 1'b1; level = 1'b0;

        // short press, no long_press
        do_reset(1'b0, 3);
        run(1'b0, 3);
        run(1'b1, 4);
        run(1'b0, 4);

        // long hold: long_press then repeats, then release
        run(1'b1, 20);
        run(1'b0, 3);

        // fall exactly on the long-threshold edge
        long_seen = 0;
        rst = 1'b0; level = 1'b1;
        for (int i = 0; i < L + 3; i++) begin
            step(1'b0, (i < L) ? 1'b1 : 1'b0);
            long_seen += long_press;
        end
        chk("no_long_at_threshold", long_seen, 0);

        // held through reset: nothing until seen low
        do_reset(1'b1, 3);
        run(1'b1, 12);
        run(1'b0, 2);
        run(1'b1, 3);
        run(1'b0, 2);

        // reset during auto-repeat, then normal operation
        run(1'b1, L + 5);
        do_reset(1'b1, 1);
        run(1'b1, 4);
        run(1'b0, 2);
        run(1'b1, 2);
        run(1'b0, 2);

        // single-cycle glitch
        run(1'b1, 1);
        run(1'b0, 3);

        // random segments with occasional reset
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 29) == 0)
                do_reset(1'($urandom_range(0, 1)), $urandom_range(1, 2));
            else
                run(1'(s & 1), (($urandom_range(0, 3) == 0) ? $urandom_range(L - 1, L + 3 * R + 2)
                                                            : $urandom_range(1, L + 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
